// File: rtl/can_fd_crc_pkg.sv
// Shared constants, types and helpers for the CAN FD CRC / stuff-count checker.
package can_fd_crc_pkg;

    localparam int unsigned CRC17_W     = 17;
    localparam int unsigned CRC21_W     = 21;
    localparam int unsigned GRAY_W      = 3;
    localparam int unsigned STUFF_CNT_W = GRAY_W + 1;

    localparam logic [CRC17_W-1:0] POLY17 = 17'h1685B;
    localparam logic [CRC21_W-1:0] POLY21 = 21'h102899;
    localparam logic [CRC17_W-1:0] INIT17 = 17'h10000;
    localparam logic [CRC21_W-1:0] INIT21 = 21'h100000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_WAIT_CRC,
        ST_DONE
    } state_t;

    // Stuff count as it appears on the bus: gray code first, parity last.
    typedef struct packed {
        logic [GRAY_W-1:0] gray;
        logic              parity;
    } stuff_cnt_t;

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic stuff_cnt_t expected_stuff_cnt(input logic [GRAY_W-1:0] dyn);
        stuff_cnt_t sc;
        sc.gray   = bin2gray(dyn);
        sc.parity = ^sc.gray;
        return sc;
    endfunction

endpackage

// File: rtl/can_fd_crc_check_if.sv
// Bit-stream, destuffer and result signals between the receive path and the CRC checker.
interface can_fd_crc_check_if;
    import can_fd_crc_pkg::*;

    logic                   sample_point;
    logic                   rx_bit;
    logic                   frame_start;
    logic                   frame_abort;
    logic                   crc_en;
    logic                   crc21_sel;
    logic [STUFF_CNT_W-1:0] stuff_cnt_rx;
    logic                   stuff_cnt_valid;
    logic [GRAY_W-1:0]      dyn_stuff_cnt;
    logic                   crc_field_done;
    logic [CRC17_W-1:0]     crc_17_i;
    logic [CRC21_W-1:0]     crc_21_i;
    logic [CRC17_W-1:0]     crc_17_calc;
    logic [CRC21_W-1:0]     crc_21_calc;
    logic                   stuff_count_error;
    logic                   crc_error;
    logic                   check_done;

    modport master (
        output sample_point, rx_bit, frame_start, frame_abort, crc_en, crc21_sel,
               stuff_cnt_rx, stuff_cnt_valid, dyn_stuff_cnt, crc_field_done,
               crc_17_i, crc_21_i,
        input  crc_17_calc, crc_21_calc, stuff_count_error, crc_error, check_done
    );

    modport slave (
        input  sample_point, rx_bit, frame_start, frame_abort, crc_en, crc21_sel,
               stuff_cnt_rx, stuff_cnt_valid, dyn_stuff_cnt, crc_field_done,
               crc_17_i, crc_21_i,
        output crc_17_calc, crc_21_calc, stuff_count_error, crc_error, check_done
    );

endinterface

// File: rtl/can_crc_lfsr.sv
// Serial CRC shift register; init reloads the seed and may absorb a bit in the same cycle.
module can_crc_lfsr #(
    parameter int unsigned         WIDTH = 17,
    parameter logic [WIDTH-1:0]    POLY  = '0,
    parameter logic [WIDTH-1:0]    INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             en,
    input  logic             serial_bit,
    output logic [WIDTH-1:0] crc
);

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] cur, input logic b);
        logic fb;
        fb = b ^ cur[WIDTH-1];
        return {cur[WIDTH-2:0], 1'b0} ^ (fb ? POLY : WIDTH'(0));
    endfunction

    logic [WIDTH-1:0] base_c;

    assign base_c = init ? INIT : crc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= INIT;
        end else if (init || en) begin
            crc <= en ? step(base_c, serial_bit) : base_c;
        end
    end

endmodule

// File: rtl/can_fd_crc_check.sv
// CAN FD receive-side CRC-17/CRC-21 calculation, CRC compare and stuff-count check.
module can_fd_crc_check
    import can_fd_crc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    can_fd_crc_check_if.slave bus
);

    state_t     state;
    logic       stuff_count_error;
    logic       crc_error;
    logic       check_done;

    logic       start_c;
    logic       lfsr_en_c;
    logic       stuff_mismatch_c;
    logic       crc_mismatch_c;
    stuff_cnt_t stuff_exp_c;

    logic [CRC17_W-1:0] crc17;
    logic [CRC21_W-1:0] crc21;

    // Abort outranks a coincident start; a start restarts from any state.
    assign start_c   = bus.frame_start & bus.sample_point & ~bus.frame_abort;
    assign lfsr_en_c = bus.sample_point & bus.crc_en & ~bus.frame_abort &
                       (start_c | (state == ST_ACCUM));

    assign stuff_exp_c      = expected_stuff_cnt(bus.dyn_stuff_cnt);
    assign stuff_mismatch_c = (bus.stuff_cnt_rx != stuff_exp_c);
    assign crc_mismatch_c   = bus.crc21_sel ? (crc21 != bus.crc_21_i)
                                            : (crc17 != bus.crc_17_i);

    can_crc_lfsr #(
        .WIDTH (CRC17_W),
        .POLY  (POLY17),
        .INIT  (INIT17)
    ) u_crc17 (
        .clk        (clk),
        .rst        (rst),
        .init       (start_c),
        .en         (lfsr_en_c),
        .serial_bit (bus.rx_bit),
        .crc        (crc17)
    );

    can_crc_lfsr #(
        .WIDTH (CRC21_W),
        .POLY  (POLY21),
        .INIT  (INIT21)
    ) u_crc21 (
        .clk        (clk),
        .rst        (rst),
        .init       (start_c),
        .en         (lfsr_en_c),
        .serial_bit (bus.rx_bit),
        .crc        (crc21)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            stuff_count_error <= 1'b0;
            crc_error         <= 1'b0;
            check_done        <= 1'b0;
        end else begin
            check_done <= 1'b0;
            if (bus.frame_abort) begin
                state             <= ST_IDLE;
                stuff_count_error <= 1'b0;
                crc_error         <= 1'b0;
            end else if (start_c) begin
                state             <= ST_ACCUM;
                stuff_count_error <= 1'b0;
                crc_error         <= 1'b0;
            end else begin
                case (state)
                    ST_ACCUM: begin
                        if (bus.stuff_cnt_valid) begin
                            stuff_count_error <= stuff_mismatch_c;
                            state             <= ST_WAIT_CRC;
                        end
                        // CRC field ended without a stuff count: flag it as a stuff-count error.
                        if (bus.crc_field_done) begin
                            crc_error  <= crc_mismatch_c;
                            check_done <= 1'b1;
                            state      <= ST_DONE;
                            if (!bus.stuff_cnt_valid) begin
                                stuff_count_error <= 1'b1;
                            end
                        end
                    end
                    ST_WAIT_CRC: begin
                        if (bus.crc_field_done) begin
                            crc_error  <= crc_mismatch_c;
                            check_done <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.crc_17_calc       = crc17;
    assign bus.crc_21_calc       = crc21;
    assign bus.stuff_count_error = stuff_count_error;
    assign bus.crc_error         = crc_error;
    assign bus.check_done        = check_done;

endmodule

// File: tb/tb_can_fd_crc_check.sv
// Directed bench for can_fd_crc_check: LFSR seed step, gray sweep, full frames, abort and edge cases.
module tb_can_fd_crc_check;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    can_fd_crc_check_if bus();

    can_fd_crc_check dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    // Counts cycles in which check_done was high (sampled before the edge updates it).
    always @(posedge clk) if (bus.check_done === 1'b1) done_cnt++;

    logic fb[$];
    logic fe[$];
    logic [16:0] m17;
    logic [20:0] m21;

    // Stuff count on the bus for dyn 0..7: {gray, even parity}.
    logic [3:0] good_sc [8] = '{4'b0000, 4'b0011, 4'b0110, 4'b0101,
                                4'b1100, 4'b1111, 4'b1010, 4'b1001};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] step17(input logic [16:0] c, input logic b);
        return {c[15:0], 1'b0} ^ ((b ^ c[16]) ? 17'h1685B : 17'h0);
    endfunction

    function automatic logic [20:0] step21(input logic [20:0] c, input logic b);
        return {c[19:0], 1'b0} ^ ((b ^ c[20]) ? 21'h102899 : 21'h0);
    endfunction

    task automatic idle_inputs();
        bus.sample_point    = 1'b0;
        bus.rx_bit          = 1'b0;
        bus.frame_start     = 1'b0;
        bus.frame_abort     = 1'b0;
        bus.crc_en          = 1'b0;
        bus.crc21_sel       = 1'b0;
        bus.stuff_cnt_rx    = 4'b0;
        bus.stuff_cnt_valid = 1'b0;
        bus.dyn_stuff_cnt   = 3'd0;
        bus.crc_field_done  = 1'b0;
        bus.crc_17_i        = 17'h0;
        bus.crc_21_i        = 21'h0;
    endtask

    task automatic pulse(input logic b, input logic en, input logic sof, input logic scv);
        @(negedge clk);
        bus.sample_point    = 1'b1;
        bus.rx_bit          = b;
        bus.crc_en          = en;
        bus.frame_start     = sof;
        bus.stuff_cnt_valid = scv;
        @(negedge clk);
        bus.sample_point    = 1'b0;
        bus.crc_en          = 1'b0;
        bus.frame_start     = 1'b0;
        bus.stuff_cnt_valid = 1'b0;
    endtask

    task automatic abort_pulse();
        @(negedge clk);
        bus.frame_abort = 1'b1;
        @(negedge clk);
        bus.frame_abort = 1'b0;
    endtask

    // SOF + random body with periodic stuff bits (crc_en=0) + stuff count 0101 for dyn=3.
    task automatic build_frame(input int n);
        logic [3:0] sc;
        sc = 4'b0101;
        fb.delete();
        fe.delete();
        fb.push_back(1'b0);
        fe.push_back(1'b1);
        for (int i = 1; i < n; i++) begin
            fb.push_back(1'($urandom_range(0, 1)));
            fe.push_back(i % 6 != 5);
        end
        for (int i = 3; i >= 0; i--) begin
            fb.push_back(sc[i]);
            fe.push_back(1'b1);
        end
        m17 = 17'h10000;
        m21 = 21'h100000;
        for (int i = 0; i < fb.size(); i++) begin
            if (fe[i]) begin
                m17 = step17(m17, fb[i]);
                m21 = step21(m21, fb[i]);
            end
        end
    endtask

    task automatic send_frame(input int upto, input logic scv_last);
        for (int i = 0; i < upto; i++) begin
            pulse(fb[i], fe[i], i == 0, scv_last && (i == fb.size() - 1));
        end
    endtask

    task automatic finish_crc(input string tag, input logic [16:0] c17, input logic [20:0] c21,
                              input logic scv, input logic [3:0] sc,
                              input logic exp_crc, input logic exp_stuff);
        int base;
        base = done_cnt;
        @(negedge clk);
        bus.crc_field_done  = 1'b1;
        bus.crc_17_i        = c17;
        bus.crc_21_i        = c21;
        bus.stuff_cnt_valid = scv;
        bus.stuff_cnt_rx    = sc;
        @(negedge clk);
        bus.crc_field_done  = 1'b0;
        bus.stuff_cnt_valid = 1'b0;
        check({tag, "_done"}, 32'(bus.check_done), 32'd1);
        check({tag, "_crc_err"}, 32'(bus.crc_error), 32'(exp_crc));
        check({tag, "_stuff_err"}, 32'(bus.stuff_count_error), 32'(exp_stuff));
        @(negedge clk);
        @(negedge clk);
        check({tag, "_done_once"}, 32'(done_cnt - base), 32'd1);
        check({tag, "_crc_err_held"}, 32'(bus.crc_error), 32'(exp_crc));
    endtask

    task automatic run_full(input string tag, input logic sel, input logic [16:0] c17,
                            input logic [20:0] c21, input logic exp_crc);
        bus.crc21_sel     = sel;
        bus.dyn_stuff_cnt = 3'd3;
        bus.stuff_cnt_rx  = 4'b0101;
        send_frame(fb.size(), 1'b1);
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b1, 1'b0, 1'b0);
        check({tag, "_calc17"}, 32'(bus.crc_17_calc), 32'(m17));
        check({tag, "_calc21"}, 32'(bus.crc_21_calc), 32'(m21));
        finish_crc(tag, c17, c21, 1'b0, 4'b0101, exp_crc, 1'b0);
    endtask

    task automatic sc_case(input string tag, input logic [2:0] dyn, input logic [3:0] sc,
                           input logic exp);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        bus.dyn_stuff_cnt   = dyn;
        bus.stuff_cnt_rx    = sc;
        bus.stuff_cnt_valid = 1'b1;
        @(negedge clk);
        bus.stuff_cnt_valid = 1'b0;
        check(tag, 32'(bus.stuff_count_error), 32'(exp));
    endtask

    initial begin
        int base;
        void'($urandom(32'd12345));
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_crc17", 32'(bus.crc_17_calc), 32'h10000);
        check("rst_crc21", 32'(bus.crc_21_calc), 32'h100000);
        rst = 1'b0;
        @(negedge clk);
        check("rst_stuff_err", 32'(bus.stuff_count_error), 32'd0);
        check("rst_crc_err", 32'(bus.crc_error), 32'd0);
        check("rst_done", 32'(bus.check_done), 32'd0);

        // One dominant SOF bit from INIT.
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        check("sof_crc17", 32'(bus.crc_17_calc), 32'h1685B);
        check("sof_crc21", 32'(bus.crc_21_calc), 32'h102899);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("noen_crc17", 32'(bus.crc_17_calc), 32'h1685B);
        abort_pulse();

        for (int d = 0; d < 8; d++) begin
            sc_case($sformatf("gray_ok_%0d", d), 3'(d), good_sc[d], 1'b0);
            sc_case($sformatf("par_bad_%0d", d), 3'(d), good_sc[d] ^ 4'b0001, 1'b1);
        end
        sc_case("gray_off_3", 3'd3, good_sc[4], 1'b1);
        sc_case("gray_off_5", 3'd5, good_sc[6], 1'b1);
        sc_case("spec_3", 3'd3, 4'b0101, 1'b0);
        sc_case("spec_5", 3'd5, 4'b1111, 1'b0);
        abort_pulse();

        // 8-byte payload, CRC-17 path.
        build_frame(92);
        run_full("f8_ok", 1'b0, m17, m21, 1'b0);
        run_full("f8_bad", 1'b0, m17 ^ 17'h1, m21, 1'b1);

        // 64-byte payload, CRC-21 path; a CRC-17 mismatch must not matter.
        build_frame(540);
        run_full("f64_ok", 1'b1, m17 ^ 17'h1, m21, 1'b0);
        run_full("f64_bad", 1'b1, m17, m21 ^ 21'h100, 1'b1);

        // Abort after 40 bits with a stuff-count error pending.
        build_frame(92);
        base = done_cnt;
        send_frame(40, 1'b0);
        sc_case_noframe: begin
            @(negedge clk);
            bus.dyn_stuff_cnt   = 3'd2;
            bus.stuff_cnt_rx    = 4'b0000;
            bus.stuff_cnt_valid = 1'b1;
            @(negedge clk);
            bus.stuff_cnt_valid = 1'b0;
            check("abort_pre_err", 32'(bus.stuff_count_error), 32'd1);
        end
        abort_pulse();
        check("abort_flag_clr", 32'(bus.stuff_count_error), 32'd0);
        check("abort_crc_clr", 32'(bus.crc_error), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - base), 32'd0);
        run_full("after_abort", 1'b0, m17, m21, 1'b0);

        // CRC field done without a stuff count.
        build_frame(30);
        bus.crc21_sel = 1'b0;
        send_frame(fb.size(), 1'b0);
        finish_crc("no_sc", m17, m21, 1'b0, 4'b0101, 1'b0, 1'b1);

        // Stuff count and CRC field done together; stuff good, CRC bad.
        build_frame(30);
        bus.dyn_stuff_cnt = 3'd3;
        send_frame(fb.size(), 1'b0);
        finish_crc("same_cyc", m17 ^ 17'h2, m21, 1'b1, 4'b0101, 1'b1, 1'b0);

        // Reset mid-frame returns to seed values.
        build_frame(30);
        send_frame(10, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_crc17", 32'(bus.crc_17_calc), 32'h10000);
        check("midrst_crc21", 32'(bus.crc_21_calc), 32'h100000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_done", 32'(bus.check_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
